// File: rtl/fft_bfly_pe.sv
// fft_bfly_pe: pipelined radix-2 complex butterfly (DIF/DIT per transaction)
// with an elaboration-time twiddle table, optional 1/2 scaling, round-half-up,
// saturation with a sticky overflow flag, and valid/ready flow control.
module fft_bfly_pe #(
   parameter int DW    = 32,
   parameter int FRAC  = 16,
   parameter int LOG2N = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 mode,
   input  logic                 scale,
   input  logic [LOG2N-2:0]     power,
   input  logic [DW-1:0]        a_re,
   input  logic [DW-1:0]        a_im,
   input  logic [DW-1:0]        b_re,
   input  logic [DW-1:0]        b_im,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DW-1:0]        fft_a_re,
   output logic [DW-1:0]        fft_a_im,
   output logic [DW-1:0]        fft_b_re,
   output logic [DW-1:0]        fft_b_im,
   output logic                 ovf,
   input  logic                 ovf_clr
);

   localparam int N  = 1 << LOG2N;
   localparam int NH = N / 2;
   localparam int TW = FRAC + 2;        // twiddle width, holds +1.0 exactly
   localparam int PW = DW + FRAC + 6;   // full-precision datapath width

   localparam logic signed [PW-1:0] ONE_P = 1;
   localparam logic signed [PW-1:0] RND0  = ONE_P <<< (FRAC - 1);
   localparam logic signed [PW-1:0] RND1  = ONE_P <<< FRAC;
   localparam logic signed [PW-1:0] MAXV  = PW'({1'b0, {(DW-1){1'b1}}});
   localparam logic signed [PW-1:0] MINV  = ~MAXV;

   generate
      if (LOG2N < 2 || LOG2N > 6) begin : g_bad_log2n
         $error("fft_bfly_pe: LOG2N must be in the range 2..6");
      end
      if (FRAC < 1 || FRAC > 29 || FRAC >= DW) begin : g_bad_frac
         $error("fft_bfly_pe: FRAC must be in 1..29 and below DW");
      end
   endgenerate

   // ---------------- twiddle table (elaboration only) ----------------
   function automatic real sin_t(input real x);
      real term, sum;
      term = x;
      sum  = x;
      for (int i = 1; i < 20; i++) begin
         term = -term * x * x / (real'(2 * i) * real'(2 * i + 1));
         sum  = sum + term;
      end
      return sum;
   endfunction

   function automatic real cos_t(input real x);
      real term, sum;
      term = 1.0;
      sum  = 1.0;
      for (int i = 1; i < 20; i++) begin
         term = -term * x * x / (real'(2 * i - 1) * real'(2 * i));
         sum  = sum + term;
      end
      return sum;
   endfunction

   // Magnitude truncated toward zero, then the sign re-applied.
   function automatic logic signed [TW-1:0] to_fix(input real v);
      real mag, sc;
      int  q;
      mag = (v < 0.0) ? -v : v;
      sc  = 1.0;
      for (int i = 0; i < FRAC; i++) sc = sc * 2.0;
      q = $rtoi(mag * sc);
      if (v < 0.0) q = -q;
      return TW'(q);
   endfunction

   // Quarter points are exact; other angles stay strictly inside (0, pi/2).
   function automatic logic signed [TW-1:0] tw_re_f(input int k);
      real th;
      if (k == 0) return to_fix(1.0);
      if (k == N / 4) return to_fix(0.0);
      if (k < N / 4) begin
         th = 2.0 * 3.14159265358979323846 * real'(k) / real'(N);
         return to_fix(cos_t(th));
      end
      th = 2.0 * 3.14159265358979323846 * real'(k - N / 4) / real'(N);
      return to_fix(-sin_t(th));
   endfunction

   function automatic logic signed [TW-1:0] tw_im_f(input int k);
      real th;
      if (k == 0) return to_fix(0.0);
      if (k == N / 4) return to_fix(-1.0);
      if (k < N / 4) begin
         th = 2.0 * 3.14159265358979323846 * real'(k) / real'(N);
         return to_fix(-sin_t(th));
      end
      th = 2.0 * 3.14159265358979323846 * real'(k - N / 4) / real'(N);
      return to_fix(-cos_t(th));
   endfunction

   logic signed [TW-1:0] tw_re_tab [NH];
   logic signed [TW-1:0] tw_im_tab [NH];

   for (genvar k = 0; k < NH; k++) begin : g_tw
      localparam logic signed [TW-1:0] TRE = tw_re_f(k);
      localparam logic signed [TW-1:0] TIM = tw_im_f(k);
      assign tw_re_tab[k] = TRE;
      assign tw_im_tab[k] = TIM;
   end

   // ---------------- handshake ----------------
   // Valid/ready: a transfer happens on a rising edge where valid && ready.
   // One global enable advances every stage together; the output register
   // only stalls when it holds valid data the consumer refuses, so in_ready
   // equals that enable and the whole pipe freezes as a unit.
   logic en;
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   // ---------------- stage 1 ----------------
   logic                 s1_v, s1_mode, s1_scale;
   logic signed [DW-1:0] s1_a_re, s1_a_im, s1_b_re, s1_b_im;
   logic signed [TW-1:0] s1_w_re, s1_w_im;

   // Capture operands, controls and the looked-up twiddle.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v <= 1'b0;
      end else if (en) begin
         s1_v <= in_valid;
         if (in_valid) begin
            s1_mode  <= mode;
            s1_scale <= scale;
            s1_a_re  <= a_re;
            s1_a_im  <= a_im;
            s1_b_re  <= b_re;
            s1_b_im  <= b_im;
            s1_w_re  <= tw_re_tab[power];
            s1_w_im  <= tw_im_tab[power];
         end
      end
   end

   // ---------------- stage 2 ----------------
   logic signed [PW-1:0] ar_e, ai_e, br_e, bi_e, wr_e, wi_e, xr_e, xi_e;
   logic signed [PW-1:0] prod_re, prod_im, base_re, base_im;
   logic signed [PW-1:0] nx_a_re, nx_a_im, nx_b_re, nx_b_im;

   // Full-precision butterfly: DIF multiplies the difference, DIT multiplies b.
   always_comb begin
      ar_e    = PW'(s1_a_re);
      ai_e    = PW'(s1_a_im);
      br_e    = PW'(s1_b_re);
      bi_e    = PW'(s1_b_im);
      wr_e    = PW'(s1_w_re);
      wi_e    = PW'(s1_w_im);
      xr_e    = s1_mode ? br_e : (ar_e - br_e);
      xi_e    = s1_mode ? bi_e : (ai_e - bi_e);
      prod_re = xr_e * wr_e - xi_e * wi_e;
      prod_im = xr_e * wi_e + xi_e * wr_e;
      base_re = (s1_mode ? ar_e : (ar_e + br_e)) <<< FRAC;
      base_im = (s1_mode ? ai_e : (ai_e + bi_e)) <<< FRAC;
      nx_a_re = s1_mode ? (base_re + prod_re) : base_re;
      nx_a_im = s1_mode ? (base_im + prod_im) : base_im;
      nx_b_re = s1_mode ? (base_re - prod_re) : prod_re;
      nx_b_im = s1_mode ? (base_im - prod_im) : prod_im;
   end

   logic                 s2_v, s2_scale;
   logic signed [PW-1:0] s2_a_re, s2_a_im, s2_b_re, s2_b_im;

   // Register the full-precision products.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_v <= 1'b0;
      end else if (en) begin
         s2_v <= s1_v;
         if (s1_v) begin
            s2_scale <= s1_scale;
            s2_a_re  <= nx_a_re;
            s2_a_im  <= nx_a_im;
            s2_b_re  <= nx_b_re;
            s2_b_im  <= nx_b_im;
         end
      end
   end

   // ---------------- stage 3 ----------------
   // Round half up at the chosen shift, then clamp; MSB of result flags a clamp.
   function automatic logic [DW:0] rnd_sat(input logic signed [PW-1:0] x,
                                           input logic sc);
      logic signed [PW-1:0] r;
      r = sc ? ((x + RND1) >>> (FRAC + 1)) : ((x + RND0) >>> FRAC);
      if (r > MAXV) return {1'b1, MAXV[DW-1:0]};
      if (r < MINV) return {1'b1, MINV[DW-1:0]};
      return {1'b0, r[DW-1:0]};
   endfunction

   logic [DW:0] rs_a_re, rs_a_im, rs_b_re, rs_b_im;
   logic        any_sat;

   // Round/saturate all four components and collect the clamp indication.
   always_comb begin
      rs_a_re = rnd_sat(s2_a_re, s2_scale);
      rs_a_im = rnd_sat(s2_a_im, s2_scale);
      rs_b_re = rnd_sat(s2_b_re, s2_scale);
      rs_b_im = rnd_sat(s2_b_im, s2_scale);
      any_sat = rs_a_re[DW] | rs_a_im[DW] | rs_b_re[DW] | rs_b_im[DW];
   end

   // Output register; ovf set wins over a same-cycle clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         fft_a_re  <= '0;
         fft_a_im  <= '0;
         fft_b_re  <= '0;
         fft_b_im  <= '0;
         ovf       <= 1'b0;
      end else begin
         if (en) begin
            out_valid <= s2_v;
            if (s2_v) begin
               fft_a_re <= rs_a_re[DW-1:0];
               fft_a_im <= rs_a_im[DW-1:0];
               fft_b_re <= rs_b_re[DW-1:0];
               fft_b_im <= rs_b_im[DW-1:0];
            end
         end
         ovf <= (ovf && !ovf_clr) || (en && s2_v && any_sat);
      end
   end

endmodule

// File: tb/tb_fft_bfly_pe.sv
// tb_fft_bfly_pe: directed checks of fft_bfly_pe with DW=32, FRAC=16, LOG2N=4.
module tb_fft_bfly_pe;

   localparam int DW    = 32;
   localparam int FRAC  = 16;
   localparam int LOG2N = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid, in_ready, mode, scale;
   logic [LOG2N-2:0]  power;
   logic [DW-1:0]     a_re, a_im, b_re, b_im;
   logic              out_valid, out_ready;
   logic [DW-1:0]     fft_a_re, fft_a_im, fft_b_re, fft_b_im;
   logic              ovf, ovf_clr;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [4*DW-1:0] exp_q[$];

   fft_bfly_pe #(.DW(DW), .FRAC(FRAC), .LOG2N(LOG2N)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .scale(scale), .power(power),
      .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
      .out_valid(out_valid), .out_ready(out_ready),
      .fft_a_re(fft_a_re), .fft_a_im(fft_a_im),
      .fft_b_re(fft_b_re), .fft_b_im(fft_b_im),
      .ovf(ovf), .ovf_clr(ovf_clr)
   );

   // clock
   always #5 clk = ~clk;

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [4*DW-1:0] obs,
                        input logic [4*DW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one butterfly with an empty pipe and wait (bounded) for its result.
   // lat counts rising edges from the handshake edge to the one raising out_valid.
   task automatic bfly(input logic m, input logic s, input logic [LOG2N-2:0] p,
                       input logic [DW-1:0] ar, input logic [DW-1:0] ai,
                       input logic [DW-1:0] br, input logic [DW-1:0] bi,
                       output int lat);
      mode = m; scale = s; power = p;
      a_re = ar; a_im = ai; b_re = br; b_im = bi;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   function automatic logic [4*DW-1:0] outs();
      return {fft_a_re, fft_a_im, fft_b_re, fft_b_im};
   endfunction

   initial begin
      int lat;
      int sent, got, stale;
      logic [4*DW-1:0] held;
      logic held_v;
      logic [DW-1:0] vr, vi, wr, wi;

      // reset
      rst = 1'b1; in_valid = 1'b0; mode = 1'b0; scale = 1'b0; power = '0;
      a_re = '0; a_im = '0; b_re = '0; b_im = '0;
      out_ready = 1'b1; ovf_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_outputs", outs(), 128'(0));
      check("rst_ovf", 128'(ovf), 128'(0));
      check("rst_in_ready", 128'(in_ready), 128'(1));
      rst = 1'b0;
      @(posedge clk); #1;

      // DIF, W=1: a=1.0, b=0.5
      bfly(1'b0, 1'b0, 3'd0, 32'h0001_0000, 32'h0, 32'h0000_8000, 32'h0, lat);
      check("dif_p0_latency", 128'(lat), 128'(3));
      check("dif_p0_out", outs(),
            {32'h0001_8000, 32'h0, 32'h0000_8000, 32'h0});
      check("dif_p0_ovf", 128'(ovf), 128'(0));
      @(posedge clk); #1;
      check("dif_p0_valid_drop", 128'(out_valid), 128'(0));

      // DIF, W=-j
      bfly(1'b0, 1'b0, 3'd4, 32'h0001_0000, 32'h0, 32'h0, 32'h0, lat);
      check("dif_p4_latency", 128'(lat), 128'(3));
      check("dif_p4_out", outs(),
            {32'h0001_0000, 32'h0, 32'h0, 32'hFFFF_0000});

      // DIT, W=W16^2
      bfly(1'b1, 1'b0, 3'd2, 32'h0, 32'h0, 32'h0001_0000, 32'h0, lat);
      check("dit_p2_latency", 128'(lat), 128'(3));
      check("dit_p2_out", outs(),
            {32'h0000_B504, 32'hFFFF_4AFC, 32'hFFFF_4AFC, 32'h0000_B504});

      // DIT, W=W16^1 applied to b=1.0 gives the table entry itself
      bfly(1'b1, 1'b0, 3'd1, 32'h0, 32'h0, 32'h0001_0000, 32'h0, lat);
      check("dit_p1_out", outs(),
            {32'h0000_EC83, 32'hFFFF_9E09, 32'hFFFF_137D, 32'h0000_61F7});

      // saturation, unscaled
      bfly(1'b0, 1'b0, 3'd0, 32'h7FFF_0000, 32'h0, 32'h7FFF_0000, 32'h0, lat);
      check("sat_out", outs(), {32'h7FFF_FFFF, 32'h0, 32'h0, 32'h0});
      check("sat_ovf_set", 128'(ovf), 128'(1));
      repeat (2) @(posedge clk);
      #1;
      check("sat_ovf_sticky", 128'(ovf), 128'(1));
      ovf_clr = 1'b1;
      @(posedge clk); #1;
      ovf_clr = 1'b0;
      check("sat_ovf_clr", 128'(ovf), 128'(0));

      // same stimulus, scaled: no clamp
      bfly(1'b0, 1'b1, 3'd0, 32'h7FFF_0000, 32'h0, 32'h7FFF_0000, 32'h0, lat);
      check("scaled_out", outs(), {32'h7FFF_0000, 32'h0, 32'h0, 32'h0});
      check("scaled_ovf", 128'(ovf), 128'(0));

      // set and clear in the same cycle: set wins
      ovf_clr = 1'b1;
      bfly(1'b0, 1'b0, 3'd0, 32'h7FFF_0000, 32'h0, 32'h7FFF_0000, 32'h0, lat);
      ovf_clr = 1'b0;
      check("ovf_set_wins", 128'(ovf), 128'(1));
      @(posedge clk); #1;

      // backpressure: 6 back-to-back, out_ready low for 5 cycles mid-stream
      sent = 0; got = 0; held_v = 1'b0; held = '0;
      mode = 1'b0; scale = 1'b0; power = '0;
      for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
         out_ready = !(cyc >= 3 && cyc < 8);
         if (sent < 6) begin
            a_re = 32'(sent + 1) << 16;
            a_im = -(32'(sent) * 32'd256);
            b_re = 32'(sent) * 32'h3000;
            b_im = 32'h0002_0000 + 32'(sent);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (held_v) check("bp_hold", outs(), held);
         if (out_valid && !out_ready) begin
            check("bp_in_ready_low", 128'(in_ready), 128'(0));
            held   = outs();
            held_v = 1'b1;
         end else begin
            held_v = 1'b0;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() > 0) check("bp_data", outs(), exp_q.pop_front());
            else check("bp_unexpected", 128'(1), 128'(0));
            got++;
         end
         if (in_valid && in_ready) begin
            vr = a_re + b_re; vi = a_im + b_im;
            wr = a_re - b_re; wi = a_im - b_im;
            exp_q.push_back({vr, vi, wr, wi});
            sent++;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      check("bp_delivered", 128'(got), 128'(6));
      check("bp_queue_empty", 128'(exp_q.size()), 128'(0));

      // reset with two butterflies in flight (ovf still set from above)
      mode = 1'b0; scale = 1'b0; power = '0;
      a_re = 32'h7FFF_0000; a_im = 32'h0; b_re = 32'h7FFF_0000; b_im = 32'h0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      a_re = 32'h0001_0000; b_re = 32'h0000_8000;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("pre_rst_ovf", 128'(ovf), 128'(1));
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_out_valid", 128'(out_valid), 128'(0));
      check("midrst_outputs", outs(), 128'(0));
      check("midrst_ovf", 128'(ovf), 128'(0));
      rst = 1'b0;
      stale = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (out_valid || ovf) stale++;
      end
      check("midrst_no_stale", 128'(stale), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fft_bfly_pe.md
Name: fft_bfly_pe

Overview:
- Parametrised, pipelined radix-2 complex butterfly for the FFT datapath. It succeeds the fixed 16-point, 32-bit twiddle-lookup PE.
- Adds generic data width, fraction width and FFT size, an elaboration-time twiddle table, and DIF/DIT mode per transaction.
- Adds optional per-stage 1/2 scaling, rounding, saturation with a sticky overflow flag, and valid/ready flow control.
- Sits between the FFT address/sequencer and the working memory; one butterfly is accepted per cycle.

Parameters:
- DW, 32: data width of each real/imag component, signed two's complement.
- FRAC, 16: fraction bits of data and twiddle (Q(DW-FRAC).FRAC).
- LOG2N, 4: log2 of FFT size N; legal range 2..6; twiddle index width is LOG2N-1.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input butterfly valid
- in_ready  out  1  PE can accept input this cycle
- mode  in  1  0=DIF, 1=DIT; sampled with the input
- scale  in  1  1=divide both outputs by 2; sampled with the input
- power  in  LOG2N-1  twiddle index k; W = W_N^k
- a_re, a_im, b_re, b_im  in  DW each  signed input operands
- out_valid  out  1  output butterfly valid
- out_ready  in  1  downstream accepts output
- fft_a_re, fft_a_im, fft_b_re, fft_b_im  out  DW each  signed results
- ovf  out  1  sticky saturation flag
- ovf_clr  in  1  clears ovf

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: all stage valids 0, out_valid=0, all fft_* outputs 0, ovf=0. Reset during operation discards in-flight butterflies with no output.
- Twiddle table:
  - W_N^k = cos(2πk/N) - j·sin(2πk/N), built at elaboration.
  - Component magnitude = floor(|value|·2^FRAC), then the sign is applied (truncation toward zero).
  - Width is FRAC+2 signed. For k=0, W = (2^FRAC, 0).
  - N=16, FRAC=16 values are fixed, for example:
    - k=1: (0xEC83, -0x61F7)
    - k=2: (0xB504, -0xB504)
    - k=4: (0, -0x10000)
- Arithmetic, full precision, no intermediate truncation:
  - DIF: A = (a+b)·2^FRAC; B = (a-b)·W.
  - DIT: A = a·2^FRAC + W·b; B = a·2^FRAC - W·b.
  - Each component is rounded: add 2^(FRAC+scale-1), then arithmetic shift right by FRAC+scale (round half up).
  - The result is saturated to [-2^(DW-1), 2^(DW-1)-1].
- Overflow flag:
  - Any saturation in any of the four components of an accepted output sets ovf on the cycle that output becomes valid.
  - ovf_clr clears ovf. A set and a clear in the same cycle leave ovf set.
- Pipeline, 3 stages:
  - S1 registers operands, mode, scale and the looked-up twiddle.
  - S2 performs the multiplies and add/sub.
  - S3 performs round, shift and saturate, and drives the outputs.
  - Latency is 3 cycles from input handshake to out_valid when not stalled.
- Handshake:
  - Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
  - Global enable en = !out_valid || out_ready. in_ready = en, combinational and registered-free.
  - When en=0 all stages hold. Outputs stay stable while out_valid && !out_ready. No data is lost or duplicated.
  - Bubbles propagate as stage-valid=0 entries.
- Throughput: 1 butterfly per cycle while out_ready=1.
- Illegal LOG2N values are an elaboration error.

Test Plan:
- DIF, power=0, scale=0 (DW=32, FRAC=16, LOG2N=4):
  - Stimulus: a=(0x00010000,0), b=(0x00008000,0).
  - Required: fft_a=(0x00018000,0), fft_b=(0x00008000,0), out_valid exactly 3 cycles after the handshake.
- DIF, power=4:
  - Stimulus: a=(0x00010000,0), b=(0,0).
  - Required: fft_a=(0x00010000,0), fft_b=(0,0xFFFF0000).
- DIT, power=2:
  - Stimulus: a=(0,0), b=(0x00010000,0).
  - Required: fft_a=(0x0000B504,0xFFFF4AFC), fft_b=(0xFFFF4AFC,0x0000B504).
- Saturation, DIF:
  - Stimulus: a=b=(0x7FFF0000,0), scale=0.
  - Required: fft_a_re=0x7FFFFFFF, ovf=1 and remains 1 until an ovf_clr pulse returns it to 0.
  - Same stimulus with scale=1: fft_a_re=0x7FFF0000, ovf stays 0.
- Backpressure:
  - Stimulus: stream 6 butterflies back-to-back, hold out_ready=0 for 5 cycles mid-stream.
  - Required: in_ready=0 while the pipeline is full, outputs held stable, all 6 results delivered in order and matching the model.
- Reset mid-stream:
  - Stimulus: assert rst with 2 butterflies in flight.
  - Required: next cycle out_valid=0, outputs 0, ovf=0; no stale output appears after reset is released.
